// File: rtl/ftoi_pipe.sv
// Pipelined float32 to signed integer converter: four rounding modes, saturating
// OUT_W-bit result, valid/ready flow control with a single global stall.
module ftoi_pipe #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned OUT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    output logic             ovf,
    output logic             inv
);

    localparam int unsigned WW = 64;
    localparam logic [WW-1:0] POS_LIM = (WW'(1) << (OUT_W - 1)) - WW'(1);
    localparam logic [WW-1:0] NEG_LIM = WW'(1) << (OUT_W - 1);

    logic             s;
    logic [7:0]       e;
    logic [22:0]      m;
    logic [23:0]      sig;
    logic [7:0]       sh;
    logic [23:0]      mask;
    logic [WW-1:0]    mag;
    logic [WW-1:0]    rmag;
    logic             guard;
    logic             sticky;
    logic             inc;
    logic             huge;
    logic [OUT_W-1:0] conv_y;
    logic             conv_ovf;
    logic             conv_inv;
    logic             en;

    // Conversion datapath; the register chain below supplies all of the latency.
    always_comb begin
        s        = x[31];
        e        = x[30:23];
        m        = x[22:0];
        sig      = {1'b1, m};
        sh       = '0;
        mask     = '0;
        mag      = '0;
        rmag     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        inc      = 1'b0;
        huge     = 1'b0;
        conv_y   = '0;
        conv_ovf = 1'b0;
        conv_inv = 1'b0;

        if (e >= 8'd150) begin
            sh = e - 8'd150;
            // A left shift of 40 or more cannot fit any legal OUT_W; flag it instead of wrapping.
            if (sh >= 8'd40) begin
                huge = 1'b1;
            end else begin
                mag = WW'(sig) << sh[5:0];
            end
        end else if (e < 8'd126) begin
            sticky = 1'b1;
        end else begin
            sh     = 8'd150 - e;
            mag    = WW'(sig >> sh[4:0]);
            guard  = sig[sh[4:0] - 5'd1];
            mask   = (24'd1 << (sh[4:0] - 5'd1)) - 24'd1;
            sticky = |(sig & mask);
        end

        unique case (mode)
            2'b00:   inc = guard;
            2'b01:   inc = 1'b0;
            2'b10:   inc = s & (guard | sticky);
            default: inc = guard & (sticky | mag[0]);
        endcase
        rmag = mag + WW'(inc);

        if (e == 8'd0) begin
            conv_y = '0;
        end else if (e == 8'hFF) begin
            if (m != 23'd0) begin
                conv_y   = OUT_W'(NEG_LIM);
                conv_inv = 1'b1;
            end else begin
                conv_y   = s ? OUT_W'(NEG_LIM) : OUT_W'(POS_LIM);
                conv_ovf = 1'b1;
            end
        end else if (!s) begin
            if (huge || rmag > POS_LIM) begin
                conv_y   = OUT_W'(POS_LIM);
                conv_ovf = 1'b1;
            end else begin
                conv_y = OUT_W'(rmag);
            end
        end else begin
            if (huge || rmag > NEG_LIM) begin
                conv_y   = OUT_W'(NEG_LIM);
                conv_ovf = 1'b1;
            end else begin
                conv_y = OUT_W'(WW'(0) - rmag);
            end
        end
    end

    logic             vld_q [LATENCY];
    logic             vld_d [LATENCY];
    logic [OUT_W-1:0] y_q   [LATENCY];
    logic [OUT_W-1:0] y_d   [LATENCY];
    logic             ovf_q [LATENCY];
    logic             ovf_d [LATENCY];
    logic             inv_q [LATENCY];
    logic             inv_d [LATENCY];

    assign en        = !vld_q[LATENCY-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[LATENCY-1];
    assign y         = y_q[LATENCY-1];
    assign ovf       = ovf_q[LATENCY-1];
    assign inv       = inv_q[LATENCY-1];

    // Whole pipe shifts on en; a stall freezes every stage including the output.
    always_comb begin
        vld_d = vld_q;
        y_d   = y_q;
        ovf_d = ovf_q;
        inv_d = inv_q;
        if (en) begin
            vld_d[0] = in_valid;
            y_d[0]   = conv_y;
            ovf_d[0] = conv_ovf;
            inv_d[0] = conv_inv;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_d[i] = vld_q[i-1];
                y_d[i]   = y_q[i-1];
                ovf_d[i] = ovf_q[i-1];
                inv_d[i] = inv_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                vld_q[i] <= 1'b0;
                y_q[i]   <= '0;
                ovf_q[i] <= 1'b0;
                inv_q[i] <= 1'b0;
            end
        end else begin
            vld_q <= vld_d;
            y_q   <= y_d;
            ovf_q <= ovf_d;
            inv_q <= inv_d;
        end
    end

endmodule
